// File: rtl/spi_regfile_pkg.sv
// Shared definitions for the SPI register file with read-back.
// Holds the frame FSM state encoding, the frame field widths and the
// helper that turns CPOL/CPHA into the SCK edge on which MOSI is sampled.
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  localparam int RW_BIT = 7;  // command bit selecting read (1) or write (0)
  localparam int ADDR_W = 7;  // command address width
  localparam int BYTE_W = 8;  // register and SPI byte width

  // MOSI is sampled on the rising SCK edge when CPOL==CPHA, else on the falling edge.
  function automatic logic sample_on_rise(input int cpol, input int cpha);
    return (cpol == cpha) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/spi_regfile_rw_sync.sv
// Two-flop synchronizer with edge pulses for one asynchronous SPI pin.
// Ports:
//   clk, rst  system clock and asynchronous active-high reset
//   din       asynchronous input pin
//   sync      synchronized level (2 clk latency)
//   rise      one-cycle pulse after sync goes 0->1
//   fall      one-cycle pulse after sync goes 1->0
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain plus one history flop used to detect edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      prev_r <= RST_VAL;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign sync = sync_r;
  assign rise = sync_r & ~prev_r;
  assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/spi_regfile_rw.sv
// SPI slave register file with read-back and per-register write strobes.
// A frame is a command byte {R/W, addr[6:0]} followed by any number of data
// bytes; writes auto-increment the address, reads stream registers out on MISO.
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   spi_sck/cs_n/mosi    SPI slave inputs, asynchronous to clk
//   spi_miso, _oe        serial read data and its output enable
//   ro_data              live values for read-only (status) registers
//   regs_flat            register contents, byte i = register i
//   wr_strobe            one-cycle pulse per register on write
module spi_regfile_rw
  import spi_regfile_pkg::*;
#(
  parameter int                    NUM_REGS   = 16,
  parameter int                    CPOL       = 0,
  parameter int                    CPHA       = 0,
  parameter logic [NUM_REGS*8-1:0] RESET_VALS = '0,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [NUM_REGS*8-1:0] ro_data,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic [NUM_REGS-1:0]   wr_strobe
);

  localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  localparam logic SCK_IDLE    = (CPOL != 0) ? 1'b1 : 1'b0;

  logic sck_sync_s, sck_rise_s, sck_fall_s;
  logic cs_n_sync_s, cs_n_rise_s, cs_n_fall_s;
  logic mosi_sync_s, mosi_rise_s, mosi_fall_s;
  logic unused_s;

  state_t              state_r, next_state_s;
  logic [2:0]          bit_cnt_r;
  logic [BYTE_W-1:0]   shift_in_r, shift_out_r, rx_byte_s, rd_byte_s;
  logic [ADDR_W-1:0]   addr_r, rd_addr_s;
  logic [BYTE_W-1:0]   regs_r    [NUM_REGS];
  logic [BYTE_W-1:0]   reg_src_s [NUM_REGS];
  logic [NUM_REGS-1:0] wr_strobe_r;
  logic                miso_r;
  logic [1:0]          settle_r;
  logic                armed_r;
  logic cs_active_s, sample_s, shift_s, byte_done_s;
  logic cmd_done_s, wr_en_s, rd_load_s, addr_inc_s, miso_shift_s;

  spi_sync_edge #(.RST_VAL(SCK_IDLE)) u_sync_sck (
    .clk(clk), .rst(rst), .din(spi_sck),
    .sync(sck_sync_s), .rise(sck_rise_s), .fall(sck_fall_s)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst(rst), .din(spi_cs_n),
    .sync(cs_n_sync_s), .rise(cs_n_rise_s), .fall(cs_n_fall_s)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(spi_mosi),
    .sync(mosi_sync_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  // Levels and pulses this block has no use for.
  assign unused_s = ^{sck_sync_s, cs_n_rise_s, cs_n_fall_s, mosi_rise_s, mosi_fall_s};

  assign rx_byte_s = {shift_in_r[BYTE_W-2:0], mosi_sync_s};

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; losing chip select always returns to IDLE.
  always_comb begin
    next_state_s = state_r;
    if (!cs_active_s) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    next_state_s = sample_s ? CMD : IDLE;
        CMD: begin
          if (cmd_done_s) begin
            next_state_s = rx_byte_s[RW_BIT] ? RDATA : WDATA;
          end else begin
            next_state_s = CMD;
          end
        end
        WDATA:   next_state_s = WDATA;
        RDATA:   next_state_s = RDATA;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // FSM outputs: edge qualification and per-byte actions.
  always_comb begin
    // Chip select only counts once cs_n has been seen high after reset.
    cs_active_s  = armed_r & ~cs_n_sync_s;
    sample_s     = cs_active_s & (SAMPLE_RISE ? sck_rise_s : sck_fall_s);
    shift_s      = cs_active_s & (SAMPLE_RISE ? sck_fall_s : sck_rise_s);
    byte_done_s  = sample_s & (bit_cnt_r == 3'd7);
    cmd_done_s   = 1'b0;
    wr_en_s      = 1'b0;
    rd_load_s    = 1'b0;
    addr_inc_s   = 1'b0;
    miso_shift_s = 1'b0;
    case (state_r)
      IDLE:  cmd_done_s = 1'b0;
      CMD: begin
        cmd_done_s = byte_done_s;
        rd_load_s  = byte_done_s & rx_byte_s[RW_BIT];
      end
      WDATA: begin
        wr_en_s    = byte_done_s;
        addr_inc_s = byte_done_s;
      end
      RDATA: begin
        rd_load_s    = byte_done_s;
        addr_inc_s   = byte_done_s;
        miso_shift_s = shift_s;
      end
      default: cmd_done_s = 1'b0;
    endcase
  end

  // Read mux: the command address on entry to RDATA, else the next address.
  always_comb begin
    rd_addr_s = (state_r == CMD) ? rx_byte_s[ADDR_W-1:0] : (addr_r + 7'd1);
    rd_byte_s = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_src_s[i] = RO_MASK[i] ? ro_data[i*BYTE_W +: BYTE_W] : regs_r[i];
      // Out-of-range addresses match no register and read as 0x00.
      rd_byte_s = rd_byte_s | ((rd_addr_s == ADDR_W'(i)) ? reg_src_s[i] : 8'h00);
    end
  end

  // Bit counter, shifters, address pointer, MISO and chip-select arming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r   <= 3'd0;
      shift_in_r  <= 8'h00;
      shift_out_r <= 8'h00;
      addr_r      <= 7'd0;
      miso_r      <= 1'b0;
      settle_r    <= 2'd0;
      armed_r     <= 1'b0;
    end else begin
      // Wait two cycles so the cs_n synchronizer reflects the pin, not its reset value.
      if (settle_r != 2'd2) begin
        settle_r <= settle_r + 2'd1;
      end
      if ((settle_r == 2'd2) && cs_n_sync_s) begin
        armed_r <= 1'b1;
      end
      if (!cs_active_s) begin
        bit_cnt_r  <= 3'd0;
        shift_in_r <= 8'h00;
      end else if (sample_s) begin
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        shift_in_r <= rx_byte_s;
      end
      if (cmd_done_s) begin
        addr_r <= rx_byte_s[ADDR_W-1:0];
      end else if (addr_inc_s) begin
        addr_r <= addr_r + 7'd1;
      end
      if (rd_load_s) begin
        shift_out_r <= rd_byte_s;
      end else if (miso_shift_s) begin
        shift_out_r <= {shift_out_r[BYTE_W-2:0], 1'b0};
      end
      if (miso_shift_s) begin
        miso_r <= shift_out_r[BYTE_W-1];
      end else if ((state_r != RDATA) || !cs_active_s) begin
        miso_r <= 1'b0;
      end
    end
  end

  // Register array and write strobes; read-only and out-of-range writes drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_strobe_r <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= RESET_VALS[i*BYTE_W +: BYTE_W];
      end
    end else begin
      wr_strobe_r <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en_s && (addr_r == ADDR_W'(i)) && !RO_MASK[i]) begin
          regs_r[i]      <= rx_byte_s;
          wr_strobe_r[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*BYTE_W +: BYTE_W] = regs_r[g];
  end

  assign spi_miso    = miso_r;
  assign spi_miso_oe = ~cs_n_sync_s;
  assign wr_strobe   = wr_strobe_r;

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Self-checking bench: one instance per SPI mode (index = {CPOL,CPHA}),
// driven by a bit-banged SPI master and checked against a byte-level model.
module tb_spi_regfile_rw;

  localparam int           HALF = 60;
  localparam logic [127:0] RV   = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  localparam logic [15:0]  RO   = 16'h0080;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   sck, cs_n, mosi, miso_w, oe_w;
  logic [127:0] ro_data;
  logic [127:0] regs_w   [4];
  logic [15:0]  strobe_w [4];

  int         n_total = 0;
  int         n_bad   = 0;
  int         strobe_cnt [4][16];
  logic [7:0] mreg [4][16];
  int         mstb [4][16];
  logic [7:0] txbuf [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_regfile_rw #(
      .NUM_REGS(16), .CPOL(g / 2), .CPHA(g % 2), .RESET_VALS(RV), .RO_MASK(RO)
    ) u_dut (
      .clk(clk), .rst(rst), .spi_sck(sck[g]), .spi_cs_n(cs_n[g]), .spi_mosi(mosi[g]),
      .spi_miso(miso_w[g]), .spi_miso_oe(oe_w[g]), .ro_data(ro_data),
      .regs_flat(regs_w[g]), .wr_strobe(strobe_w[g])
    );
  end

  always @(posedge clk) begin
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 16; i++) begin
        if (strobe_w[m][i]) strobe_cnt[m][i] <= strobe_cnt[m][i] + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 16; i++) mreg[m][i] = RV[i*8 +: 8];
  endtask

  function automatic logic [7:0] model_read(input int m, input logic [6:0] a);
    if (a >= 7'd16) return 8'h00;
    if (RO[a[3:0]]) return ro_data[a[3:0]*8 +: 8];
    return mreg[m][a[3:0]];
  endfunction

  task automatic model_write(input int m, input logic [6:0] a, input logic [7:0] d);
    if (a < 7'd16 && !RO[a[3:0]]) begin
      mreg[m][a[3:0]] = d;
      mstb[m][a[3:0]]++;
    end
  endtask

  function automatic logic [127:0] model_flat(input int m);
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = mreg[m][i];
    return f;
  endfunction

  task automatic check_state(input int m);
    check_val($sformatf("m%0d regs", m), regs_w[m], model_flat(m));
    for (int i = 0; i < 16; i++)
      check_val($sformatf("m%0d strobes r%0d", m, i), 128'(strobe_cnt[m][i]), 128'(mstb[m][i]));
  endtask

  // One byte (or its first nbits) as SPI master; rx collects MISO at sample edges.
  task automatic xfer(input int m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      if (m % 2 == 0) begin
        mosi[m] = tx[7-b];
        #(HALF);
        rx = {rx[6:0], miso_w[m]};
        sck[m] = ~sck[m];
        #(HALF);
        sck[m] = ~sck[m];
      end else begin
        sck[m] = ~sck[m];
        mosi[m] = tx[7-b];
        #(HALF);
        rx = {rx[6:0], miso_w[m]};
        sck[m] = ~sck[m];
        #(HALF);
      end
    end
  endtask

  task automatic do_frame(input int m, input logic [7:0] cmd, input int n);
    logic [7:0] rx;
    logic [6:0] a;
    a = cmd[6:0];
    cs_n[m] = 1'b0;
    #(HALF);
    check_val($sformatf("m%0d oe", m), 128'(oe_w[m]), 128'h1);
    xfer(m, cmd, 8, rx);
    for (int k = 0; k < n; k++) begin
      xfer(m, txbuf[k], 8, rx);
      if (cmd[7]) check_val($sformatf("m%0d rd a%0h", m, a), 128'(rx), 128'(model_read(m, a)));
      else model_write(m, a, txbuf[k]);
      a = a + 7'd1;
    end
    #(HALF);
    cs_n[m] = 1'b1;
    #(2*HALF);
    check_state(m);
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] cmd;
    int         n;

    rst = 1'b1;
    ro_data = {$urandom, $urandom, $urandom, $urandom};
    ro_data[63:56] = 8'h5A;
    for (int m = 0; m < 4; m++) begin
      sck[m]  = (m >= 2) ? 1'b1 : 1'b0;
      cs_n[m] = 1'b1;
      mosi[m] = 1'b0;
    end
    model_reset();
    #30;
    for (int m = 0; m < 4; m++) begin
      check_val($sformatf("m%0d reset regs", m), regs_w[m], RV);
      check_val($sformatf("m%0d reset strobe", m), 128'(strobe_w[m]), 128'h0);
      check_val($sformatf("m%0d reset miso", m), 128'(miso_w[m]), 128'h0);
      check_val($sformatf("m%0d reset oe", m), 128'(oe_w[m]), 128'h0);
    end
    #20 rst = 1'b0;
    #100;

    // Mode 0 burst write into 2..4.
    txbuf[0] = 8'hAA; txbuf[1] = 8'hBB; txbuf[2] = 8'hCC;
    do_frame(0, 8'h02, 3);

    // Mode 3 write then read back with address increment.
    txbuf[0] = 8'h3C;
    do_frame(3, 8'h05, 1);
    txbuf[0] = 8'($urandom); txbuf[1] = 8'($urandom);
    do_frame(3, 8'h85, 2);

    // Read-only register: write ignored, read returns live input.
    txbuf[0] = 8'hFF;
    do_frame(0, 8'h07, 1);
    do_frame(0, 8'h87, 1);

    // Modes 1 and 2: reads past the end, write wrap from 127 to 0.
    for (int m = 1; m <= 2; m++) begin
      do_frame(m, 8'h8F, 2);
      txbuf[0] = 8'h66; txbuf[1] = 8'(8'h40 + m);
      do_frame(m, 8'h7F, 2);
    end

    // Mode 0: chip select drops after 5 data bits.
    cs_n[0] = 1'b0;
    #(HALF);
    xfer(0, 8'h01, 8, rx);
    xfer(0, 8'h99, 5, rx);
    #(HALF);
    cs_n[0] = 1'b1;
    #(2*HALF);
    check_state(0);
    txbuf[0] = 8'h11;
    do_frame(0, 8'h01, 1);

    // Mode 0: reset in the middle of a data byte, released with cs_n still low.
    cs_n[0] = 1'b0;
    #(HALF);
    xfer(0, 8'h03, 8, rx);
    xfer(0, 8'hE7, 4, rx);
    #20 rst = 1'b1;
    model_reset();
    #30;
    for (int m = 0; m < 4; m++) begin
      check_val($sformatf("m%0d midreset regs", m), regs_w[m], RV);
      check_val($sformatf("m%0d midreset miso", m), 128'(miso_w[m]), 128'h0);
      check_val($sformatf("m%0d midreset oe", m), 128'(oe_w[m]), 128'h0);
    end
    #20 rst = 1'b0;
    #60;
    xfer(0, 8'h04, 8, rx);
    xfer(0, 8'h77, 8, rx);
    #(HALF);
    cs_n[0] = 1'b1;
    #(2*HALF);
    for (int m = 0; m < 4; m++) check_state(m);
    txbuf[0] = 8'h12; txbuf[1] = 8'h34;
    do_frame(0, 8'h03, 2);

    // Random frames in every mode.
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 12; k++) begin
        ro_data = {$urandom, $urandom, $urandom, $urandom};
        cmd[7] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) cmd[6:0] = 7'(120 + $urandom_range(0, 7));
        else cmd[6:0] = 7'($urandom_range(0, 19));
        n = $urandom_range(0, 4);
        for (int j = 0; j < 8; j++) txbuf[j] = 8'($urandom);
        do_frame(m, cmd, n);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_regfile_rw.md
# spi_regfile_rw

Parametrised SPI slave register file with read-back: the read/write successor to the synthesizer's RX-only SPI register bank. It receives an address/command byte followed by a burst of data bytes over SPI. Supported CPOL/CPHA modes are set at elaboration. Writes go into a register array of configurable depth; reads shift register contents out on MISO. Each written register raises a single-cycle strobe, so downstream blocks (oscillator, streaming DAC path) can react to the write.

## Interface
Parameters:
- NUM_REGS, 16: number of 8-bit registers; legal range 1..128.
- CPOL, 0: SPI clock idle level.
- CPHA, 0: SPI clock phase. The sample edge is rising when CPOL==CPHA, falling otherwise; the shift edge is the opposite edge.
- RESET_VALS, all zero: NUM_REGS*8-bit flat vector; byte i is the reset value of register i.
- RO_MASK, all zero: NUM_REGS-bit vector; bit i=1 makes register i read-only (status).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- spi_sck  in  1  SPI clock, asynchronous to clk.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- spi_miso_oe  out  1  MISO output enable for the top-level uio_oe; equals synchronized !cs_n.
- ro_data  in  NUM_REGS*8  live values for read-only registers.
- regs_flat  out  NUM_REGS*8  current register contents; byte i is register i.
- wr_strobe  out  NUM_REGS  bit i pulses for one clk cycle when register i is written.

## Operation
- Inputs pass through 2-flop synchronizers (cs_n resets to 1). Sample and shift edges are detected from the synchronized SCK.
- Frame format: command byte {R/W, addr[6:0]} with R/W=1 meaning read, followed by N≥0 data bytes.
- FSM states:
  - IDLE: entered while cs_n=1. Goes to CMD on the first sample edge with cs_n=0.
  - CMD: receives 8 bits. On the 8th bit it latches addr and goes to WDATA or RDATA.
  - WDATA: every 8th bit writes the byte to addr, then increments addr.
  - RDATA: every 8th bit increments addr and loads the outbound shifter with the byte at the new addr.
- Entering RDATA loads the shifter with the byte at addr.
- Read source per register: ro_data byte if RO_MASK[i]=1, else register i. ro_data is sampled at load time.
- Address rules:
  - addr ≥ NUM_REGS: writes are ignored and reads return 0x00.
  - addr increments modulo 128 (7-bit wrap, 127→0).
- Writes to RO_MASK registers are ignored and raise no strobe.
- cs_n deassert at any point: state returns to IDLE, bit count to 0, and any partial byte is discarded. Registers written earlier in the frame keep their new values.
- spi_miso is 0 in IDLE, CMD and WDATA.
- Reset values: regs_flat=RESET_VALS, wr_strobe=0, spi_miso=0, spi_miso_oe=0, state IDLE, addr 0.

## Timing
- SCK high and low phases must each last ≥3 clk periods, which limits f_sck to ≤ f_clk/6.
- Write latency: the register update and its wr_strobe occur in the same clk cycle, 3 clk cycles after the 8th sample edge of the byte reaches the pin (2 synchronizer cycles + 1 edge-detect/update cycle).
- MISO changes only in the cycle after a detected shift edge. At the shift edge following the 8th sample edge of a byte, MISO presents bit 7 of the next outbound byte. This applies to every mode, including the first read byte after the command.
- spi_miso_oe follows cs_n with 2 clk cycles of latency.
- Reset asserted mid-frame forces all reset values immediately; no partial write is committed.
- A reset release while cs_n=0 stays in IDLE until a cs_n rising edge has been seen.

## Structure
- Package spi_regfile_pkg holds:
  - state enum (IDLE, CMD, WDATA, RDATA);
  - RW_BIT=7, ADDR_W=7, BYTE_W=8;
  - a function giving the sample-edge polarity from CPOL/CPHA.
- Sub-module spi_sync_edge: 2-flop synchronizer plus rise/fall pulse outputs; instantiated once each for sck, cs_n and mosi.

## Test plan
- Mode 0, NUM_REGS=16: frame 0x02,0xAA,0xBB,0xCC → regs 2,3,4 become AA,BB,CC; wr_strobe bits 2,3,4 each pulse exactly once; no other register changes.
- Mode 3: write 0x05=0x3C, then read frame 0x85 plus 2 dummy bytes → MISO returns 0x3C followed by the reset value of reg 6.
- RO_MASK[7]=1, ro_data byte 7=0x5A: write 0x07=0xFF → register unchanged and no strobe; reading 0x87 → 0x5A.
- Modes 1 and 2: burst read starting at 0x8F with NUM_REGS=16 → byte 1 is reg 15, byte 2 is 0x00 (addr 16 out of range). Write at 0x7F with 2 bytes → addr wraps to 0 and reg 0 takes the second byte.
- Mode 0: deassert cs_n after 5 bits of a data byte → no write and no strobe. The next frame 0x01,0x11 writes reg 1=0x11 normally.
- Mode 0: assert rst after 4 bits of a data byte → all regs_flat equal RESET_VALS, spi_miso and spi_miso_oe equal 0, and the following frame decodes correctly.
